alu_seq: RTL

//  Registered, handshaked successor of the unicycle ALU. Same 3-bit opcode set;
//  ADD/SUB/AND/OR/SHL/SHR complete in 1 cycle, MUL/DIV are iterative (N cycles).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 69 ++++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode set, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic neg;
    logic c;
    logic v;
    logic dz;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of alu_seq. Both sides use valid/ready: a transfer happens
// on a rising edge where valid and ready are both high; valid never waits on ready.
interface alu_seq_if #(parameter int N = 20) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   Opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Result;
  logic [N-1:0] Rem;
  logic         Z;
  logic         NEG;
  logic         C;
  logic         V;
  logic         DZ;

  modport master (
    output in_valid, A, B, Opcode, out_ready,
    input  in_ready, out_valid, Result, Rem, Z, NEG, C, V, DZ
  );

  modport slave (
    input  in_valid, A, B, Opcode, out_ready,
    output in_ready, out_valid, Result, Rem, Z, NEG, C, V, DZ
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: one 2N-bit shift register and one N+1-bit adder shared by
// radix-2 shift-add multiply and restoring unsigned divide, one bit per cycle.
module alu_muldiv_iter #(
  parameter int N = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_div,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] acc_next
);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [2*N-1:0]   acc_q;
  logic [N-1:0]     m_q;
  logic             div_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N:0]       add_a;
  logic [N:0]       add_b;
  logic             add_cin;
  logic [N+1:0]     sum;

  // DIV subtracts via two's complement; the carry-out then means "no borrow".
  always_comb begin
    if (div_q) begin
      add_a   = {acc_q[2*N-1:N], acc_q[N-1]};
      add_b   = ~{1'b0, m_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[2*N-1:N]};
      add_b   = acc_q[0] ? {1'b0, m_q} : '0;
      add_cin = 1'b0;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + (N+2)'(add_cin);
    if (div_q) begin
      if (sum[N+1]) acc_next = {sum[N-1:0], acc_q[N-2:0], 1'b1};
      else          acc_next = {add_a[N-1:0], acc_q[N-2:0], 1'b0};
    end else begin
      acc_next = {sum[N:0], acc_q[N-1:1]};
    end
  end

  assign done = busy_q && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      acc_q  <= {{N{1'b0}}, (is_div ? a : b)};
      m_q    <= is_div ? b : a;
      div_q  <= is_div;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith ops plus iterative MUL/DIV.
// Results and flags are captured only on entry to DONE and held until taken.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output alu_state_e dbg_state
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MUL  = ST_MUL;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_DONE = ST_DONE;
  localparam logic [N-1:0] SH_LIM = N'(N);

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   res_q, rem_q;
  alu_flags_t     flags_q;
  alu_op_e        op;
  logic           accept, start, ld_en, iter_done;
  logic [2*N-1:0] acc_next;
  logic [N-1:0]   res1, n_res, n_rem;
  logic           c1, v1, n_c, n_v, n_dz;

  assign op     = alu_op_e'(bus.Opcode);
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    res1 = '0;
    c1   = 1'b0;
    v1   = 1'b0;
    case (op)
      OP_ADD: begin
        {c1, res1} = {1'b0, bus.A} + {1'b0, bus.B};
        v1 = (bus.A[N-1] == bus.B[N-1]) && (res1[N-1] != bus.A[N-1]);
      end
      OP_SUB: begin
        res1 = bus.A - bus.B;
        c1   = bus.A < bus.B;
        v1   = (bus.A[N-1] != bus.B[N-1]) && (res1[N-1] != bus.A[N-1]);
      end
      OP_AND: res1 = bus.A & bus.B;
      OP_OR:  res1 = bus.A | bus.B;
      OP_SHL: res1 = (bus.B >= SH_LIM) ? '0 : (bus.A << bus.B);
      OP_SHR: res1 = (bus.B >= SH_LIM) ? '0 : (bus.A >> bus.B);
      default: ;
    endcase
  end

  // Divide by zero skips the engine entirely and completes like a 1-cycle op.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ld_en   = 1'b0;
    n_res   = '0;
    n_rem   = '0;
    n_c     = 1'b0;
    n_v     = 1'b0;
    n_dz    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d = S_MUL;
            start   = 1'b1;
          end else if (op == OP_DIV && bus.B != '0) begin
            state_d = S_DIV;
            start   = 1'b1;
          end else begin
            state_d = S_DONE;
            ld_en   = 1'b1;
            if (op == OP_DIV) begin
              n_res = '1;
              n_rem = bus.A;
              n_dz  = 1'b1;
            end else begin
              n_res = res1;
              n_c   = c1;
              n_v   = v1;
            end
          end
        end
      end
      S_MUL, S_DIV: begin
        if (iter_done) begin
          state_d = S_DONE;
          ld_en   = 1'b1;
          n_res   = acc_next[N-1:0];
          if (state_q == S_MUL) n_c   = |acc_next[2*N-1:N];
          else                  n_rem = acc_next[2*N-1:N];
        end
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      rem_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_en) begin
        res_q   <= n_res;
        rem_q   <= n_rem;
        flags_q <= '{z: (n_res == '0), neg: n_res[N-1], c: n_c, v: n_v, dz: n_dz};
      end
    end
  end

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_div   (op == OP_DIV),
    .a        (bus.A),
    .b        (bus.B),
    .done     (iter_done),
    .acc_next (acc_next)
  );

  // in_ready is gated by reset so every output reads 0 while rst_n is low.
  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Result    = res_q;
  assign bus.Rem       = rem_q;
  assign bus.Z         = flags_q.z;
  assign bus.NEG       = flags_q.neg;
  assign bus.C         = flags_q.c;
  assign bus.V         = flags_q.v;
  assign bus.DZ        = flags_q.dz;
  assign dbg_state     = alu_state_e'(state_q);
endmodule
